// File: rtl/soc_router_pkg.sv
// Shared types and default address map for the core data router.
package soc_router_pkg;

  typedef enum logic [1:0] {
    TGT_RAM    = 2'd0,
    TGT_PERIPH = 2'd1,
    TGT_ERR    = 2'd2
  } router_tgt_e;

  localparam logic [31:0] DEF_RAM_BASE    = 32'h0001_0000;
  localparam logic [31:0] DEF_RAM_SIZE    = 32'h0001_0000;
  localparam logic [31:0] DEF_PERIPH_BASE = 32'h2000_0000;
  localparam logic [31:0] DEF_PERIPH_SIZE = 32'h0001_0000;

  localparam logic [31:0] ROUTER_ERR_RDATA = 32'hBADC_0FFE;

  // Region sizes are powers of two with size-aligned bases, so a mask compare suffices.
  function automatic logic addr_in_region(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] size);
    return (addr & ~(size - 32'd1)) == base;
  endfunction

endpackage

// File: rtl/core_data_inf.sv
// CV32E40P-style data bus: request/grant address phase, rvalid response phase.
interface CORE_DATA_INF;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;

  modport Master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport Slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/router_id_fifo.sv
// Ordered FIFO of target IDs for in-flight transactions; synchronous active-low reset.
module router_id_fifo
  import soc_router_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push,
  input  router_tgt_e push_id,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output router_tgt_e head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  router_tgt_e    mem [DEPTH];
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= TGT_RAM;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= push_id;
        wptr      <= next_ptr(wptr);
      end
      if (do_pop) begin
        rptr <= next_ptr(rptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

endmodule

// File: rtl/core_data_router.sv
// Routes the core data port to data RAM or peripheral space with in-order responses.
// Define DATA_ROUTER_ERR_RESP_EN to answer unmapped accesses internally and expose err_o.
module core_data_router
  import soc_router_pkg::*;
#(
  parameter logic [31:0] RAM_BASE        = DEF_RAM_BASE,
  parameter logic [31:0] RAM_SIZE        = DEF_RAM_SIZE,
  parameter logic [31:0] PERIPH_BASE     = DEF_PERIPH_BASE,
  parameter logic [31:0] PERIPH_SIZE     = DEF_PERIPH_SIZE,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  CORE_DATA_INF.Slave  s_data,
  CORE_DATA_INF.Master m_ram,
  CORE_DATA_INF.Master m_periph
`ifdef DATA_ROUTER_ERR_RESP_EN
  ,
  output logic         err_o
`endif
);

  router_tgt_e sel_tgt;
  router_tgt_e head_tgt;
  logic        fifo_full;
  logic        fifo_empty;
  logic        stall;
  logic        fwd;
  logic        sel_ram;
  logic        sel_periph;
  logic        tgt_gnt;
  logic        push;
  logic        pop;
  logic        head_rvalid;
  logic [31:0] head_rdata;
  logic        err_rvalid_q;

  always_comb begin
    sel_tgt = TGT_PERIPH;
    if (addr_in_region(s_data.data_addr, RAM_BASE, RAM_SIZE)) begin
      sel_tgt = TGT_RAM;
    end else if (addr_in_region(s_data.data_addr, PERIPH_BASE, PERIPH_SIZE)) begin
      sel_tgt = TGT_PERIPH;
    end else begin
`ifdef DATA_ROUTER_ERR_RESP_EN
      sel_tgt = TGT_ERR;
`else
      sel_tgt = TGT_PERIPH;
`endif
    end
  end

  // Outstanding entries always share one target, so the head stands for all of them.
  assign stall      = fifo_full || (!fifo_empty && (sel_tgt != head_tgt));
  assign fwd        = rst_ni && s_data.data_req && !stall;
  assign sel_ram    = (sel_tgt == TGT_RAM);
  assign sel_periph = (sel_tgt == TGT_PERIPH);

  assign m_ram.data_req      = fwd && sel_ram;
  assign m_ram.data_addr     = sel_ram ? s_data.data_addr  : '0;
  assign m_ram.data_we       = sel_ram ? s_data.data_we    : 1'b0;
  assign m_ram.data_be       = sel_ram ? s_data.data_be    : '0;
  assign m_ram.data_wdata    = sel_ram ? s_data.data_wdata : '0;

  assign m_periph.data_req   = fwd && sel_periph;
  assign m_periph.data_addr  = sel_periph ? s_data.data_addr  : '0;
  assign m_periph.data_we    = sel_periph ? s_data.data_we    : 1'b0;
  assign m_periph.data_be    = sel_periph ? s_data.data_be    : '0;
  assign m_periph.data_wdata = sel_periph ? s_data.data_wdata : '0;

  always_comb begin
    tgt_gnt = 1'b0;
    case (sel_tgt)
      TGT_RAM:    tgt_gnt = m_ram.data_gnt;
      TGT_PERIPH: tgt_gnt = m_periph.data_gnt;
      TGT_ERR:    tgt_gnt = 1'b1;
      default:    tgt_gnt = 1'b0;
    endcase
  end

  assign s_data.data_gnt = fwd && tgt_gnt;
  assign push            = s_data.data_req && s_data.data_gnt;

  router_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (push),
    .push_id (sel_tgt),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head_tgt)
  );

  // Error target answers exactly one cycle after its grant; writes there are discarded.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_rvalid_q <= 1'b0;
    end else begin
      err_rvalid_q <= push && (sel_tgt == TGT_ERR);
    end
  end

`ifdef DATA_ROUTER_ERR_RESP_EN
  assign err_o = push && (sel_tgt == TGT_ERR);
`endif

  always_comb begin
    head_rvalid = 1'b0;
    head_rdata  = '0;
    case (head_tgt)
      TGT_RAM: begin
        head_rvalid = m_ram.data_rvalid;
        head_rdata  = m_ram.data_rdata;
      end
      TGT_PERIPH: begin
        head_rvalid = m_periph.data_rvalid;
        head_rdata  = m_periph.data_rdata;
      end
      TGT_ERR: begin
        head_rvalid = err_rvalid_q;
        head_rdata  = ROUTER_ERR_RDATA;
      end
      default: begin
        head_rvalid = 1'b0;
        head_rdata  = '0;
      end
    endcase
  end

  assign s_data.data_rvalid = rst_ni && !fifo_empty && head_rvalid;
  assign s_data.data_rdata  = s_data.data_rvalid ? head_rdata : '0;
  assign pop                = s_data.data_rvalid;

endmodule

// File: tb/tb_core_data_router.sv
// Directed self-checking bench for core_data_router (either build of DATA_ROUTER_ERR_RESP_EN).
module tb_core_data_router;

  logic clk_i;
  logic rst_ni;
  int   n_err;
  int   n_chk;

  CORE_DATA_INF s_bus ();
  CORE_DATA_INF ram_bus ();
  CORE_DATA_INF per_bus ();

`ifdef DATA_ROUTER_ERR_RESP_EN
  logic err_o;
`endif

  core_data_router #(
    .RAM_BASE        (32'h0001_0000),
    .RAM_SIZE        (32'h0001_0000),
    .PERIPH_BASE     (32'h2000_0000),
    .PERIPH_SIZE     (32'h0001_0000),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .s_data   (s_bus),
    .m_ram    (ram_bus),
    .m_periph (per_bus)
`ifdef DATA_ROUTER_ERR_RESP_EN
    ,
    .err_o    (err_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic core(input logic req, input logic [31:0] addr, input logic we,
                      input logic [3:0] be, input logic [31:0] wdata);
    s_bus.data_req   = req;
    s_bus.data_addr  = addr;
    s_bus.data_we    = we;
    s_bus.data_be    = be;
    s_bus.data_wdata = wdata;
  endtask

  task automatic ram(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    ram_bus.data_gnt    = gnt;
    ram_bus.data_rvalid = rvalid;
    ram_bus.data_rdata  = rdata;
  endtask

  task automatic per(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    per_bus.data_gnt    = gnt;
    per_bus.data_rvalid = rvalid;
    per_bus.data_rdata  = rdata;
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 ns later, well before the rising edge.
  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    rst_ni = 1'b0;
    core(1'b0, '0, 1'b0, '0, '0);
    ram(1'b0, 1'b0, '0);
    per(1'b0, 1'b0, '0);

    // Reset: outputs held quiet even with live activity on every bus
    step();
    core(1'b1, 32'h0001_0040, 1'b0, 4'hF, '0);
    ram(1'b1, 1'b1, 32'hFFFF_FFFF);
    per(1'b1, 1'b1, 32'hEEEE_EEEE);
    settle();
    check("rst_gnt",     32'(s_bus.data_gnt),    32'd0);
    check("rst_rvalid",  32'(s_bus.data_rvalid), 32'd0);
    check("rst_rdata",   s_bus.data_rdata,       32'd0);
    check("rst_ram_req", 32'(ram_bus.data_req),  32'd0);
    check("rst_per_req", 32'(per_bus.data_req),  32'd0);
`ifdef DATA_ROUTER_ERR_RESP_EN
    check("rst_err_o",   32'(err_o),             32'd0);
`endif
    step();
    core(1'b0, '0, 1'b0, '0, '0);
    ram(1'b0, 1'b0, '0);
    per(1'b0, 1'b0, '0);
    step();
    rst_ni = 1'b1;

    // Single RAM read, response two cycles after grant
    step();
    core(1'b1, 32'h0001_0040, 1'b0, 4'hF, '0);
    ram(1'b1, 1'b0, '0);
    settle();
    check("rd_ram_req",  32'(ram_bus.data_req),  32'd1);
    check("rd_ram_addr", ram_bus.data_addr,      32'h0001_0040);
    check("rd_gnt",      32'(s_bus.data_gnt),    32'd1);
    check("rd_per_req",  32'(per_bus.data_req),  32'd0);
    step();
    core(1'b0, '0, 1'b0, '0, '0);
    ram(1'b0, 1'b0, '0);
    settle();
    check("rd_wait_rvalid", 32'(s_bus.data_rvalid), 32'd0);
    step();
    ram(1'b0, 1'b1, 32'h1234_5678);
    settle();
    check("rd_rvalid", 32'(s_bus.data_rvalid), 32'd1);
    check("rd_rdata",  s_bus.data_rdata,       32'h1234_5678);
    step();
    ram(1'b0, 1'b0, 32'h1234_5678);
    settle();
    check("rd_rdata_idle", s_bus.data_rdata, 32'd0);

    // Two outstanding reads fill the tracker; a third stalls until the first response
    step();
    core(1'b1, 32'h0001_0100, 1'b0, 4'hF, '0);
    ram(1'b1, 1'b0, '0);
    settle();
    check("b2b_gnt0", 32'(s_bus.data_gnt), 32'd1);
    step();
    core(1'b1, 32'h0001_0104, 1'b0, 4'hF, '0);
    settle();
    check("b2b_gnt1", 32'(s_bus.data_gnt), 32'd1);
    step();
    core(1'b1, 32'h0001_0108, 1'b0, 4'hF, '0);
    settle();
    check("full_gnt",     32'(s_bus.data_gnt),   32'd0);
    check("full_ram_req", 32'(ram_bus.data_req), 32'd0);
    step();
    ram(1'b1, 1'b1, 32'hAAAA_0001);
    settle();
    check("full_pop_gnt", 32'(s_bus.data_gnt),    32'd0);
    check("b2b_rvalid0",  32'(s_bus.data_rvalid), 32'd1);
    check("b2b_rdata0",   s_bus.data_rdata,       32'hAAAA_0001);
    step();
    ram(1'b1, 1'b0, '0);
    settle();
    check("after_pop_gnt", 32'(s_bus.data_gnt), 32'd1);
    step();
    core(1'b0, '0, 1'b0, '0, '0);
    ram(1'b0, 1'b1, 32'hAAAA_0002);
    settle();
    check("b2b_rdata1", s_bus.data_rdata, 32'hAAAA_0002);
    step();
    ram(1'b0, 1'b1, 32'hAAAA_0003);
    settle();
    check("b2b_rdata2", s_bus.data_rdata, 32'hAAAA_0003);

    // RAM read outstanding holds off a peripheral write until the RAM response
    step();
    core(1'b1, 32'h0001_0200, 1'b0, 4'hF, '0);
    ram(1'b1, 1'b0, '0);
    settle();
    check("mix_ram_gnt", 32'(s_bus.data_gnt), 32'd1);
    step();
    core(1'b1, 32'h2000_0004, 1'b1, 4'hF, 32'hDEAD_BEEF);
    ram(1'b0, 1'b0, '0);
    per(1'b1, 1'b0, '0);
    settle();
    check("mix_per_held", 32'(per_bus.data_req), 32'd0);
    check("mix_gnt_held", 32'(s_bus.data_gnt),   32'd0);
    step();
    ram(1'b0, 1'b1, 32'h0000_0055);
    settle();
    check("mix_ram_rdata",  s_bus.data_rdata,      32'h0000_0055);
    check("mix_per_held2",  32'(per_bus.data_req), 32'd0);
    step();
    ram(1'b0, 1'b0, '0);
    settle();
    check("mix_per_req",   32'(per_bus.data_req), 32'd1);
    check("mix_per_we",    32'(per_bus.data_we),  32'd1);
    check("mix_per_be",    32'(per_bus.data_be),  32'h0000_000F);
    check("mix_per_wdata", per_bus.data_wdata,    32'hDEAD_BEEF);
    check("mix_per_gnt",   32'(s_bus.data_gnt),   32'd1);
    check("mix_ram_req",   32'(ram_bus.data_req), 32'd0);
    step();
    core(1'b0, '0, 1'b0, '0, '0);
    per(1'b0, 1'b1, '0);
    settle();
    check("mix_per_rvalid", 32'(s_bus.data_rvalid), 32'd1);
    step();
    per(1'b0, 1'b0, '0);

    // Unmapped read
`ifdef DATA_ROUTER_ERR_RESP_EN
    step();
    core(1'b1, 32'h4000_0000, 1'b0, 4'hF, '0);
    settle();
    check("err_gnt",     32'(s_bus.data_gnt),   32'd1);
    check("err_o_pulse", 32'(err_o),            32'd1);
    check("err_per_req", 32'(per_bus.data_req), 32'd0);
    check("err_ram_req", 32'(ram_bus.data_req), 32'd0);
    step();
    core(1'b0, '0, 1'b0, '0, '0);
    settle();
    check("err_rvalid", 32'(s_bus.data_rvalid), 32'd1);
    check("err_rdata",  s_bus.data_rdata,       32'hBADC_0FFE);
    check("err_o_low",  32'(err_o),             32'd0);
    step();
    settle();
    check("err_rvalid_done", 32'(s_bus.data_rvalid), 32'd0);
`else
    step();
    core(1'b1, 32'h4000_0000, 1'b0, 4'hF, '0);
    per(1'b1, 1'b0, '0);
    settle();
    check("unmap_per_req",  32'(per_bus.data_req), 32'd1);
    check("unmap_per_addr", per_bus.data_addr,     32'h4000_0000);
    check("unmap_gnt",      32'(s_bus.data_gnt),   32'd1);
    step();
    core(1'b0, '0, 1'b0, '0, '0);
    per(1'b0, 1'b1, 32'h0000_0077);
    settle();
    check("unmap_rdata", s_bus.data_rdata, 32'h0000_0077);
    step();
    per(1'b0, 1'b0, '0);
`endif

    // Spurious peripheral rvalid: tracker empty, then with a RAM read at the head
    step();
    per(1'b0, 1'b1, 32'h0000_0099);
    settle();
    check("spur_empty_rvalid", 32'(s_bus.data_rvalid), 32'd0);
    check("spur_empty_rdata",  s_bus.data_rdata,       32'd0);
    step();
    per(1'b0, 1'b0, '0);
    core(1'b1, 32'h0001_0300, 1'b0, 4'hF, '0);
    ram(1'b1, 1'b0, '0);
    settle();
    check("spur_next_gnt", 32'(s_bus.data_gnt), 32'd1);
    step();
    core(1'b0, '0, 1'b0, '0, '0);
    ram(1'b0, 1'b0, '0);
    per(1'b0, 1'b1, 32'h0000_0098);
    settle();
    check("spur_head_rvalid", 32'(s_bus.data_rvalid), 32'd0);
    step();
    per(1'b0, 1'b0, '0);
    ram(1'b0, 1'b1, 32'h0000_1111);
    settle();
    check("spur_next_rdata", s_bus.data_rdata, 32'h0000_1111);
    step();
    ram(1'b0, 1'b0, '0);

    // Reset with a RAM read outstanding; the late response must be discarded
    step();
    core(1'b1, 32'h0001_0400, 1'b0, 4'hF, '0);
    ram(1'b1, 1'b0, '0);
    settle();
    check("mid_gnt", 32'(s_bus.data_gnt), 32'd1);
    step();
    core(1'b0, '0, 1'b0, '0, '0);
    ram(1'b0, 1'b0, '0);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    ram(1'b0, 1'b1, 32'h0000_BEEF);
    settle();
    check("mid_late_rvalid", 32'(s_bus.data_rvalid), 32'd0);
    step();
    ram(1'b1, 1'b0, '0);
    core(1'b1, 32'h0001_0500, 1'b0, 4'hF, '0);
    settle();
    check("post_rst_gnt", 32'(s_bus.data_gnt), 32'd1);
    step();
    core(1'b0, '0, 1'b0, '0, '0);
    ram(1'b0, 1'b1, 32'h0000_2222);
    settle();
    check("post_rst_rdata", s_bus.data_rdata, 32'h0000_2222);
    step();
    ram(1'b0, 1'b0, '0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
